pe_load_scheduler: RTL and testbench

//  Clocked sequencer that loads and feeds the partial-sum PE array of the convolution layer.
//  On start it reads each PE's filter row from weight memory. It sends every PE its weights as

---
 rtl/pe_load_scheduler.sv | 160 ++++++++++++++++
 tb/tb_pe_load_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_load_scheduler.sv
// Sequencer that streams filter-row weights, then the spike ifmap, to the partial-sum PE array
// over a single valid/ready packet port.
module pe_load_scheduler #(
  parameter int NUM_PE         = 5,
  parameter int FILTER_SIZE    = 5,
  parameter int IFMAP_SIZE     = 25,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int SPIKES_PER_PKT = 16,
  parameter int ADDR_W         = 4,
  parameter int IDX_W          = 5,
  parameter int PE_BASE_ADDR   = 0,
  localparam int TOTAL_SPIKES  = IFMAP_SIZE * IFMAP_SIZE,
  localparam int NUM_WORDS     = (TOTAL_SPIKES + SPIKES_PER_PKT - 1) / SPIKES_PER_PKT,
  localparam int DATA_W        = (2 * WEIGHT_WIDTH > SPIKES_PER_PKT) ? 2 * WEIGHT_WIDTH : SPIKES_PER_PKT,
  localparam int PKT_W         = ADDR_W + IDX_W + 1 + DATA_W,
  localparam int WA_W          = (NUM_PE * FILTER_SIZE > 1) ? $clog2(NUM_PE * FILTER_SIZE) : 1,
  localparam int IA_W          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      w_rd_en,
  output logic [WA_W-1:0]           w_rd_addr,
  input  logic [WEIGHT_WIDTH-1:0]   w_rd_data,
  output logic                      i_rd_en,
  output logic [IA_W-1:0]           i_rd_addr,
  input  logic [SPIKES_PER_PKT-1:0] i_rd_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [PKT_W-1:0]          pkt_data
);

  localparam int WPP    = (FILTER_SIZE + 1) / 2;
  localparam int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int PAIR_W = (WPP > 1) ? $clog2(WPP) : 1;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] W_RD0  = 4'd1;
  localparam logic [3:0] W_RD1  = 4'd2;
  localparam logic [3:0] W_CAP  = 4'd3;
  localparam logic [3:0] W_SEND = 4'd4;
  localparam logic [3:0] I_RD   = 4'd5;
  localparam logic [3:0] I_CAP  = 4'd6;
  localparam logic [3:0] I_SEND = 4'd7;
  localparam logic [3:0] FIN    = 4'd8;

  logic [3:0]                       state;
  logic [PE_W-1:0]                  pe_cnt;
  logic [PAIR_W-1:0]                pair_cnt;
  logic [IA_W-1:0]                  word_cnt;
  logic signed [WEIGHT_WIDTH-1:0]   w_lo_p1;
  logic signed [WEIGHT_WIDTH-1:0]   w_hi_p2;
  logic [SPIKES_PER_PKT-1:0]        word_p1;
  logic                             lo_ok;
  logic                             hi_ok;
  logic                             xfer;

  // Clears spike positions past the end of the ifmap in the final word.
  function automatic logic [SPIKES_PER_PKT-1:0] tail_mask(input logic [IA_W-1:0] n);
    logic [SPIKES_PER_PKT-1:0] m;
    for (int b = 0; b < SPIKES_PER_PKT; b++)
      m[b] = ((int'(n) * SPIKES_PER_PKT + b) < TOTAL_SPIKES);
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] pack_weights(input logic signed [WEIGHT_WIDTH-1:0] lo,
                                                     input logic signed [WEIGHT_WIDTH-1:0] hi);
    return DATA_W'({hi, lo});
  endfunction

  function automatic logic [DATA_W-1:0] pack_spikes(input logic [SPIKES_PER_PKT-1:0] w);
    return DATA_W'(w);
  endfunction

  assign lo_ok = (2 * int'(pair_cnt)) < FILTER_SIZE;
  assign hi_ok = (2 * int'(pair_cnt) + 1) < FILTER_SIZE;
  assign xfer  = pkt_valid && pkt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pe_cnt   <= '0;
      pair_cnt <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE:   if (start) state <= W_RD0;
        W_RD0:  state <= W_RD1;
        W_RD1:  state <= W_CAP;
        W_CAP:  state <= W_SEND;
        W_SEND: begin
          if (xfer) begin
            if (pair_cnt == PAIR_W'(WPP - 1)) begin
              pair_cnt <= '0;
              if (pe_cnt == PE_W'(NUM_PE - 1)) begin
                pe_cnt <= '0;
                state  <= I_RD;
              end else begin
                pe_cnt <= pe_cnt + PE_W'(1);
                state  <= W_RD0;
              end
            end else begin
              pair_cnt <= pair_cnt + PAIR_W'(1);
              state    <= W_RD0;
            end
          end
        end
        I_RD:   state <= I_CAP;
        I_CAP:  state <= I_SEND;
        I_SEND: begin
          if (xfer) begin
            if (pe_cnt == PE_W'(NUM_PE - 1)) begin
              pe_cnt <= '0;
              if (word_cnt == IA_W'(NUM_WORDS - 1)) begin
                word_cnt <= '0;
                state    <= FIN;
              end else begin
                word_cnt <= word_cnt + IA_W'(1);
                state    <= I_RD;
              end
            end else begin
              pe_cnt <= pe_cnt + PE_W'(1);
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1/p2: memory read data captured the cycle after each strobe
  always_ff @(posedge clk) begin
    if (state == W_RD1) w_lo_p1 <= lo_ok ? w_rd_data : '0;
    if (state == W_CAP) w_hi_p2 <= hi_ok ? w_rd_data : '0;
    if (state == I_CAP) word_p1 <= i_rd_data & tail_mask(word_cnt);
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    w_rd_en   = ((state == W_RD0) && lo_ok) || ((state == W_RD1) && hi_ok);
    w_rd_addr = '0;
    if (w_rd_en)
      w_rd_addr = WA_W'(int'(pe_cnt) * FILTER_SIZE + 2 * int'(pair_cnt) + ((state == W_RD1) ? 1 : 0));
    i_rd_en   = (state == I_RD);
    i_rd_addr = i_rd_en ? word_cnt : '0;
    pkt_valid = (state == W_SEND) || (state == I_SEND);
    pkt_data  = '0;
    if (state == W_SEND)
      pkt_data = {ADDR_W'(PE_BASE_ADDR + int'(pe_cnt)), IDX_W'(pe_cnt), 1'b0,
                  pack_weights(w_lo_p1, w_hi_p2)};
    else if (state == I_SEND)
      pkt_data = {ADDR_W'(PE_BASE_ADDR + int'(pe_cnt)), IDX_W'(pe_cnt), 1'b1,
                  pack_spikes(word_p1)};
  end

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Directed bench for pe_load_scheduler: packet contents, handshake stability, abort and tail masking.
module tb_pe_load_scheduler;

  localparam int NPKT = 215;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, w_rd_en, i_rd_en, pkt_valid, pkt_ready;
  logic [4:0]  w_rd_addr;
  logic [7:0]  w_rd_data;
  logic [5:0]  i_rd_addr;
  logic [15:0] i_rd_data;
  logic [25:0] pkt_data;

  logic        start6, busy6, done6, w_rd_en6, i_rd_en6, pkt_valid6, pkt_ready6;
  logic [4:0]  w_rd_addr6;
  logic [7:0]  w_rd_data6;
  logic [0:0]  i_rd_addr6;
  logic [15:0] i_rd_data6;
  logic [25:0] pkt_data6;

  logic [7:0]  wmem [0:24];
  logic [15:0] imem [0:39];
  logic [25:0] got  [0:NPKT-1];

  int total = 0;
  int bad   = 0;
  int rx, dones, busy_cyc, first_wen, first_vld, last_hs_c, done_c;
  bit aborted;

  always #5 clk = ~clk;

  pe_load_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data)
  );

  pe_load_scheduler #(.IFMAP_SIZE(5)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .busy(busy6), .done(done6),
    .w_rd_en(w_rd_en6), .w_rd_addr(w_rd_addr6), .w_rd_data(w_rd_data6),
    .i_rd_en(i_rd_en6), .i_rd_addr(i_rd_addr6), .i_rd_data(i_rd_data6),
    .pkt_valid(pkt_valid6), .pkt_ready(pkt_ready6), .pkt_data(pkt_data6)
  );

  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
    if (i_rd_en) i_rd_data <= imem[i_rd_addr];
  end

  function automatic logic [25:0] exp_pkt(input int i);
    int p, j, n;
    logic [7:0]  lo, hi;
    logic [15:0] d;
    logic        op;
    if (i < 15) begin
      p  = i / 3;
      j  = i % 3;
      lo = (2 * j < 5) ? wmem[p * 5 + 2 * j] : 8'h00;
      hi = (2 * j + 1 < 5) ? wmem[p * 5 + 2 * j + 1] : 8'h00;
      d  = {hi, lo};
      op = 1'b0;
    end else begin
      n  = (i - 15) / 5;
      p  = (i - 15) % 5;
      d  = imem[n];
      for (int b = 0; b < 16; b++)
        if (n * 16 + b >= 625) d[b] = 1'b0;
      op = 1'b1;
    end
    return {4'(p), 5'(p), op, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int pct, input bit poke_start, input int abort_rx);
    logic [25:0] prev;
    bit stalled;
    bit fin;
    stalled = 0; fin = 0; prev = '0;
    rx = 0; dones = 0; busy_cyc = 0; first_wen = -1; first_vld = -1;
    last_hs_c = -1; done_c = -1; aborted = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      if (stalled) begin
        chk("stall_valid", 32'(pkt_valid), 32'd1);
        chk("stall_data", 32'(pkt_data), 32'(prev));
      end
      if (busy) busy_cyc++;
      if (w_rd_en && first_wen < 0) first_wen = c;
      if (pkt_valid && first_vld < 0) first_vld = c;
      if (done) begin
        dones++;
        done_c = c;
        fin = 1;
      end
      if (abort_rx >= 0 && rx == abort_rx && pkt_valid) begin
        rst = 1'b1;
        aborted = 1;
        fin = 1;
      end else begin
        pkt_ready = ($urandom_range(0, 99) < pct);
        start = poke_start && (c == 100 || done);
        if (pkt_valid && pkt_ready) begin
          if (rx < NPKT) begin
            got[rx] = pkt_data;
            chk("pkt", 32'(pkt_data), 32'(exp_pkt(rx)));
          end
          rx++;
          last_hs_c = c;
        end
        stalled = pkt_valid && !pkt_ready;
        prev = pkt_data;
        step();
      end
    end
    if (!fin) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_wen"}, 32'(w_rd_en), 32'd0);
    chk({tag, "_ien"}, 32'(i_rd_en), 32'd0);
    chk({tag, "_vld"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_data"}, 32'(pkt_data), 32'd0);
    chk({tag, "_waddr"}, 32'(w_rd_addr), 32'd0);
    chk({tag, "_iaddr"}, 32'(i_rd_addr), 32'd0);
  endtask

  initial begin
    int in6;
    logic [15:0] d6 [0:9];
    rst = 1'b1; start = 1'b0; pkt_ready = 1'b0;
    start6 = 1'b0; pkt_ready6 = 1'b1; w_rd_data6 = 8'h00; i_rd_data6 = 16'hFFFF;
    for (int i = 0; i < 25; i++) wmem[i] = 8'(i + 1);
    for (int i = 0; i < 40; i++) imem[i] = 16'hFFFF;
    step(); step(); step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Test 1: ramp weights, all-ones ifmap, ready tied high
    run_load(100, 0, -1);
    chk("t1_first_wen", 32'(first_wen), 32'd0);
    chk("t1_first_vld", 32'(first_vld), 32'd3);
    chk("t1_busy_cycles", 32'(busy_cyc), 32'd341);
    chk("t1_pkts", 32'(rx), 32'd215);
    chk("t1_dones", 32'(dones), 32'd1);
    chk("t1_done_lat", 32'(done_c), 32'(last_hs_c + 1));
    chk("t1_pkt0", 32'(got[0]), 32'h0000201);
    chk("t1_pkt2", 32'(got[2]), 32'h0000005);
    chk("t1_pkt3", 32'(got[3]), 32'h0420706);
    chk("t1_pkt214", 32'(got[214]), 32'h1090001);
    chk("t1_idle_after", 32'(busy), 32'd0);
    step();

    // Test 2: all weights -1
    for (int i = 0; i < 25; i++) wmem[i] = 8'hFF;
    run_load(100, 0, -1);
    chk("t2_pkt0_data", 32'(got[0][15:0]), 32'h0000FFFF);
    chk("t2_pkt2_data", 32'(got[2][15:0]), 32'h000000FF);
    chk("t2_pkt5_data", 32'(got[5][15:0]), 32'h000000FF);
    chk("t2_pkts", 32'(rx), 32'd215);
    step();

    // Test 3: random contents, ~30% ready duty
    for (int i = 0; i < 25; i++) wmem[i] = 8'($urandom);
    for (int i = 0; i < 40; i++) imem[i] = 16'($urandom);
    run_load(30, 0, -1);
    chk("t3_pkts", 32'(rx), 32'd215);
    chk("t3_dones", 32'(dones), 32'd1);
    step();

    // Test 4: start re-pulsed mid-run and on the done cycle
    run_load(60, 1, -1);
    start = 1'b0;
    chk("t4_pkts", 32'(rx), 32'd215);
    chk("t4_dones", 32'(dones), 32'd1);
    chk("t4_busy_after_done_start", 32'(busy), 32'd0);
    step();
    chk("t4_still_idle", 32'(busy), 32'd0);
    chk("t4_no_extra_done", 32'(done), 32'd0);

    // Test 5: reset during I_SEND of word 10, then a clean replay
    run_load(100, 0, 67);
    chk("t5_aborted", 32'(aborted), 32'd1);
    step();
    chk_idle_outputs("t5_abort");
    rst = 1'b0;
    step();
    chk("t5_quiet_vld", 32'(pkt_valid), 32'd0);
    chk("t5_quiet_busy", 32'(busy), 32'd0);
    run_load(100, 0, -1);
    chk("t5_replay_pkts", 32'(rx), 32'd215);
    chk("t5_replay_pkt0", 32'(got[0]), 32'(exp_pkt(0)));
    chk("t5_replay_dones", 32'(dones), 32'd1);

    // Test 6: 5x5 ifmap, tail of word 1 masked even though memory reads all ones
    in6 = 0;
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    for (int c = 0; c < 500 && !done6; c++) begin
      if (pkt_valid6 && pkt_ready6 && pkt_data6[16]) begin
        if (in6 < 10) d6[in6] = pkt_data6[15:0];
        in6++;
      end
      step();
    end
    chk("t6_done", 32'(done6), 32'd1);
    chk("t6_in_pkts", 32'(in6), 32'd10);
    chk("t6_word0", 32'(d6[0]), 32'h0000FFFF);
    chk("t6_word0_pe4", 32'(d6[4]), 32'h0000FFFF);
    chk("t6_word1", 32'(d6[5]), 32'h000001FF);
    chk("t6_word1_pe4", 32'(d6[9]), 32'h000001FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
